// File: rtl/prbs_xnor_checker.sv
// Receive-side checker for XNOR-feedback PRBS (taps WIDTH, WIDTH-1): self-syncs, then flags mismatches.
// Optional error counter built only when PRBS_ERR_COUNT_EN is defined; otherwise err_count is tied to 0.
module prbs_xnor_checker #(
    parameter int WIDTH     = 7,
    parameter int LOCK_CNT  = 8,
    parameter int LOSS_ERRS = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WERR_W  = $clog2(LOSS_ERRS + 1);

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]         state;
    logic [WIDTH-1:0]   sr;
    logic [FILL_W-1:0]  fill_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [3:0]         win_cnt;
    logic [WERR_W-1:0]  win_errs;

    logic              pred;
    logic              miss;
    logic              sr_full;
    logic              lockup;
    logic              win_wrap;
    logic [WERR_W-1:0] win_errs_nxt;
    logic              gain;
    logic              loss;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign pred         = ~(sr[WIDTH-1] ^ sr[WIDTH-2]);
    assign miss         = in_bit ^ pred;
    assign sr_full      = (fill_cnt == FILL_W'(WIDTH));
    assign lockup       = &sr;
    assign win_wrap     = (win_cnt == 4'd15);
    assign win_errs_nxt = win_errs + WERR_W'(miss);

    // All-ones is the XNOR lockup state: it predicts itself, so it must never build toward lock.
    assign gain = (state == HUNT) && in_valid && sr_full && !miss && !lockup &&
                  (match_cnt == MATCH_W'(LOCK_CNT - 1));
    assign loss = (state == LOCK) && in_valid && miss &&
                  (win_errs_nxt == WERR_W'(LOSS_ERRS));

    assign locked = state[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            sr        <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_errs  <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                if (state == HUNT) begin
                    sr <= {sr[WIDTH-2:0], in_bit};
                    if (!sr_full)
                        fill_cnt <= fill_cnt + FILL_W'(1);
                    else if (miss || lockup)
                        match_cnt <= '0;
                    else
                        match_cnt <= match_cnt + MATCH_W'(1);
                    if (gain)
                        state <= LOCK;
                end else begin
                    // Flywheel on the prediction so a received error cannot corrupt the reference.
                    sr        <= {sr[WIDTH-2:0], pred};
                    err_pulse <= miss;
                    if (loss) begin
                        state     <= HUNT;
                        fill_cnt  <= '0;
                        match_cnt <= '0;
                        win_cnt   <= '0;
                        win_errs  <= '0;
                    end else begin
                        win_cnt  <= win_cnt + 4'd1;
                        win_errs <= win_wrap ? '0 : win_errs_nxt;
                    end
                end
            end
        end
    end

`ifdef PRBS_ERR_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_count <= '0;
        else if (clear)
            err_count <= '0;
        else if ((state == LOCK) && in_valid && miss)
            err_count <= sat_inc(err_count);
    end
`else
    logic             unused_clear;
    logic [CNT_W-1:0] unused_sat;
    assign unused_clear = clear;
    assign unused_sat   = sat_inc('0);
    assign err_count    = '0;
`endif

endmodule

// File: tb/tb_prbs_xnor_checker.sv
// Scoreboard bench for prbs_xnor_checker (CNT_W=4): stimulus pushes expectations, a monitor pops and compares.
module tb_prbs_xnor_checker;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_bit;
    logic          clear;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;

    prbs_xnor_checker #(
        .WIDTH(7), .LOCK_CNT(8), .LOSS_ERRS(4), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          lk;
        logic          pl;
        logic [CW-1:0] cn;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [6:0] g;
    int         raw;

    function automatic logic [CW-1:0] ecnt(input int n);
`ifdef PRBS_ERR_COUNT_EN
        return (n > 15) ? CW'(15) : CW'(n);
`else
        return CW'(0);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic send_bit(input logic b, input logic clr, input logic el, input logic ep);
        exp_t e;
        if (clr) raw = 0;
        else if (ep) raw++;
        e.lk = el;
        e.pl = ep;
        e.cn = ecnt(raw);
        exp_q.push_back(e);
        in_bit   = b;
        in_valid = 1'b1;
        clear    = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic send(input logic flip, input logic clr, input logic el, input logic ep);
        logic b;
        b = ~(g[6] ^ g[5]);
        g = {g[5:0], b};
        send_bit(b ^ flip, clr, el, ep);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        logic v;
        forever begin
            @(posedge clk);
            v = in_valid && !reset;
            @(negedge clk);
            if (v) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("locked", locked, e.lk);
                    chk("err_pulse", err_pulse, e.pl);
                    chk("err_count", err_count, e.cn);
                end
            end else begin
                chk("pulse_idle", err_pulse, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic f;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        clear    = 1'b0;
        g        = '0;
        raw      = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", locked, 1'b0);
        chk("rst_pulse", err_pulse, 1'b0);
        chk("rst_count", err_count, '0);
        reset = 1'b0;

        // Clean stream: lock on valid bit 15
        for (int i = 1; i <= 40; i++) send(1'b0, 1'b0, (i >= 15), 1'b0);

        // Single flipped bit, then clean bits with gaps (locked index 25..36)
        send(1'b0, 1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            send(1'b0, 1'b0, 1'b1, 1'b0);
            idle(1 + i % 3);
        end

        // Align to a window start, then 3 errors in each of two windows
        send(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 38; i < 48; i++) send(1'b0, 1'b0, 1'b1, 1'b0);
        for (int o = 0; o < 32; o++) begin
            f = (o == 2) || (o == 5) || (o == 8) || (o == 16) || (o == 23) || (o == 31);
            send(f, 1'b0, 1'b1, f);
        end

        // Four errors in one window: loss on the 4th, relock after 15 clean bits
        send(1'b0, 1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 15; i++) send(1'b0, 1'b0, (i == 15), 1'b0);

        // Fourth error lands on the window wrap bit
        send(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 11; i++) send(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 15; i++) send(1'b0, 1'b0, (i == 15), 1'b0);

        // Twenty isolated errors: counter saturates
        send(1'b0, 1'b1, 1'b1, 1'b0);
        for (int e = 0; e < 20; e++) begin
            send(1'b1, 1'b0, 1'b1, 1'b1);
            for (int i = 0; i < 15; i++) send(1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Clear on an error cycle wins; then one more error
        send(1'b1, 1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset mid-cycle
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("async_locked", locked, 1'b0);
        chk("async_pulse", err_pulse, 1'b0);
        chk("async_count", err_count, '0);
        raw = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Constant ones never lock
        for (int i = 0; i < 100; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
